data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words of storage; power of two.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles between request acceptance and response, legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port MemRead, input, 1 bit: load request from the processor.
REQ-006 SHALL have port MemWrite, input, 1 bit: store request from the processor.
REQ-007 SHALL have port A, input, 32 bits: byte address (processor ALUResult).
REQ-008 SHALL have port funct3, input, 3 bits: RV32I access size/sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
REQ-009 SHALL have port WD, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port RD, output, 32 bits: load data, extended per funct3.
REQ-011 SHALL have port Ready, output, 1 bit: one-cycle pulse marking response completion.
REQ-012 SHALL have port Err, output, 1 bit: misaligned-access flag, valid with Ready.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-014 In IDLE, SHALL accept a request when MemRead or MemWrite is high and capture A, funct3, WD, and the request type.
REQ-015 SHALL go to WAIT if LATENCY>0 and load the counter with LATENCY-1; otherwise go directly to RESP.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to RESP when it equals 0.
REQ-017 In RESP, SHALL assert Ready for exactly one cycle, perform the store write or drive the load RD, then return to IDLE.
REQ-018 Response latency SHALL be LATENCY+1 cycles from the acceptance edge to Ready high.
REQ-019 Inputs outside IDLE SHALL be ignored; a new request is accepted no earlier than the cycle after Ready.
REQ-020 If MemRead and MemWrite are both high, SHALL perform the store only and drive RD=0.
REQ-021 Word index SHALL be A[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-022 Stores SHALL use byte enables: SB writes lane A[1:0]; SH writes lanes {A[1],0} and {A[1],1}; SW writes all four lanes.
REQ-023 Loads SHALL select the addressed lane(s), sign-extend for LB/LH, and zero-extend for LBU/LHU.
REQ-024 RD SHALL hold its value until the next load response and be 0 after a store response.
REQ-025 Unsupported funct3 values SHALL be treated as word access.

Reset
REQ-026 While reset is high, SHALL force state IDLE, counter 0, RD=0, Ready=0, Err=0.
REQ-027 Reset mid-operation SHALL abort the pending access with no memory write.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With DMEM_MISALIGN_TRAP_EN defined, a halfword access with A[0]=1 or a word access with A[1:0]!=0 SHALL complete with Ready and Err=1, perform no write, and drive RD=0.
REQ-030 Without DMEM_MISALIGN_TRAP_EN, Err SHALL be tied to 0 and low address bits below the access size SHALL be ignored (the access is forced aligned).

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and the funct3 size/sign constants.
REQ-032 SHALL contain one sub-module, dmem_lane_ext, as a combinational load lane-select and extension unit.
REQ-033 Storage SHALL be an inferred synchronous-write array of DEPTH x 32 bits.

Verification
REQ-034 SW 0xDEADBEEF to A=0x10, then LW from 0x10, LATENCY=2 -> Ready 3 cycles after each request; RD=0xDEADBEEF.
REQ-035 SB 0x7F to 0x21, then LB from 0x21 -> RD=0x0000007F; SB 0x80 to 0x22, then LB/LBU from 0x22 -> 0xFFFFFF80 / 0x00000080; other bytes of word 0x20 are unchanged.
REQ-036 SH 0x8001 to 0x32, then LH/LHU from 0x32 -> 0xFFFF8001 / 0x00008001; LW from 0x30 -> upper half 0x8001.
REQ-037 Reset asserted in WAIT during an SW to 0x40 -> no Ready; a later LW from 0x40 returns the old contents.
REQ-038 With the macro defined, LW from 0x13 -> Ready with Err=1 and RD=0; without it -> Err=0 and the word at 0x10 is returned.
REQ-039 LW from 0x400 with DEPTH=256 -> returns the word at 0x000 (wrap); MemRead and MemWrite both high -> store only, RD=0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM states, access-size
// decode, RV32I funct3 load/store encodings and the captured request payload.
package data_mem_responder_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Access size derived from funct3
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // RV32I funct3 encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wait-counter width (LATENCY is limited to 0..15)
    localparam int unsigned CNT_W = 4;

    // Request fields captured at acceptance
    typedef struct packed {
        logic        wr;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } req_t;

    // Unsupported encodings fall through to a word access
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_BYTE;
            F3_H, F3_HU: f3_size = SZ_HALF;
            F3_W:        f3_size = SZ_WORD;
            default:     f3_size = SZ_WORD;
        endcase
    endfunction

    // Only LB and LH sign-extend
    function automatic logic f3_signed(input logic [2:0] f3);
        f3_signed = (f3 == F3_B) || (f3 == F3_H);
    endfunction

endpackage

// File: rtl/dmem_lane_ext.sv
// Combinational load path: selects the addressed byte/halfword lane of a
// memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   word_i  - full 32-bit memory word
//   lane_i  - byte address bits [1:0]; halfwords use lane_i[1] only
//   size_i  - access size
//   sign_i  - 1: sign-extend, 0: zero-extend (ignored for words)
//   data_c  - extended load data
module dmem_lane_ext
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic        sign_i,
    output logic [31:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection
    always_comb begin
        case (lane_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extension to 32 bits
    always_comb begin
        data_c = word_i;
        case (size_i)
            SZ_BYTE: data_c = {{24{sign_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_c = {{16{sign_i & half_sel[15]}}, half_sel};
            default: data_c = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder for an RV32I core: accepts one load/store at a time,
// waits LATENCY cycles, then completes with a one-cycle Ready pulse.
// Optional macro: DMEM_MISALIGN_TRAP_EN - misaligned halfword/word accesses
// complete with Err=1, no write and RD=0. Without it, Err is always 0 and
// low address bits below the access size are ignored.
// Parameters: DEPTH (32-bit words, power of two), LATENCY (0..15).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   MemRead, MemWrite   - load / store request (both high: store only)
//   A                   - byte address, wraps modulo DEPTH*4
//   funct3              - RV32I size/sign encoding
//   WD                  - right-aligned store data
//   RD                  - load data, held until the next response
//   Ready               - one-cycle completion pulse
//   Err                 - misaligned-access flag, valid with Ready
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] A,
    input  logic [2:0]  funct3,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        Ready,
    output logic        Err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = AW + 2;
    localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    a_q, a_d;
    req_t             req_q, req_d;
    logic [31:0]      rd_q, rd_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    idx_c;
    logic [31:0]      rword_c;
    logic [31:0]      load_c;
    size_e            size_c;
    logic             sign_c;
    logic             mis_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic             mem_we_c;

    // Address bits above the wrapped range are deliberately discarded
    logic unused_a_hi;
    assign unused_a_hi = ^A[31:IW];

    assign idx_c   = a_q[IW-1:2];
    assign rword_c = mem[idx_c];
    assign size_c  = f3_size(req_q.funct3);
    assign sign_c  = f3_signed(req_q.funct3);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis_c = ((size_c == SZ_HALF) && a_q[0]) ||
                   ((size_c == SZ_WORD) && (a_q[1:0] != 2'b00));
`else
    assign mis_c = 1'b0;
`endif

    // Load lane select and extension
    dmem_lane_ext u_lane_ext (
        .word_i (rword_c),
        .lane_i (a_q[1:0]),
        .size_i (size_c),
        .sign_i (sign_c),
        .data_c (load_c)
    );

    // Store byte enables; data is replicated so every enabled lane sees it
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = req_q.wdata;
        case (size_c)
            SZ_BYTE: begin
                be_c    = 4'b0001 << a_q[1:0];
                wdata_c = {4{req_q.wdata[7:0]}};
            end
            SZ_HALF: begin
                be_c    = a_q[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_q.wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = req_q.wdata;
            end
        endcase
    end

    // Write happens on the RESP edge unless reset aborts it
    assign mem_we_c = (state_q == ST_RESP) && req_q.wr && !mis_c && !reset;

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        req_d   = req_q;
        rd_d    = rd_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    a_d          = A[IW-1:0];
                    req_d.wr     = MemWrite;
                    req_d.funct3 = funct3;
                    req_d.wdata  = WD;
                    if (LATENCY > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                ready_d = 1'b1;
                err_d   = mis_c;
                rd_d    = (mis_c || req_q.wr) ? 32'd0 : load_c;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            req_q   <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage: byte-enabled synchronous write, never cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
                end
            end
        end
    end

    assign RD    = rd_q;
    assign Ready = ready_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model
// predicts each response at issue time; a negedge monitor pops and compares.
module tb_data_mem_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned NBYTES  = DEPTH * 4;
    localparam int unsigned BW      = $clog2(NBYTES);

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] A = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic        Ready;
    logic        Err;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .A        (A),
        .funct3   (funct3),
        .WD       (WD),
        .RD       (RD),
        .Ready    (Ready),
        .Err      (Err)
    );

    logic [7:0]  mem_b [NBYTES];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rd  = '0;
    logic        armed    = 1'b0;
    logic        rst_at_edge = 1'b0;

    always @(posedge clk) rst_at_edge <= reset;

    // Reference model: byte-addressed memory, little-endian
    task automatic model_access(input logic wr, input logic [31:0] a,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output exp_t e);
        int unsigned n;
        int unsigned base;
        logic [31:0] v;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        base = a % NBYTES;
        e.err = 1'b0;
        e.rd  = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((base % n) != 0) begin
            e.err = 1'b1;
            return;
        end
`endif
        base = base - (base % n);
        if (wr) begin
            for (int unsigned i = 0; i < n; i++) begin
                mem_b[BW'(base + i)] = 8'(wd >> (8 * i));
            end
        end else begin
            v = '0;
            for (int unsigned i = 0; i < n; i++) begin
                v = v | (32'(mem_b[BW'(base + i)]) << (8 * i));
            end
            if (n < 4 && !f3[2] && v[8*n-1]) begin
                v = v | (32'hFFFF_FFFF << (8 * n));
            end
            e.rd = v;
        end
    endtask

    // Monitor: reset values, responses, and RD hold between responses
    always @(negedge clk) begin
        if (rst_at_edge) begin
            armed   = 1'b1;
            last_rd = '0;
            n_checks++;
            if (RD !== 32'd0 || Ready !== 1'b0 || Err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: got RD=%08h Ready=%0b Err=%0b, expected all zero",
                         RD, Ready, Err);
            end
        end else if (armed) begin
            if (Ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ready: got Ready=1 RD=%08h, expected no response", RD);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (RD !== mon_e.rd || Err !== mon_e.err) begin
                        n_fail++;
                        $display("FAIL response: got RD=%08h Err=%0b, expected RD=%08h Err=%0b",
                                 RD, Err, mon_e.rd, mon_e.err);
                    end
                    last_rd = mon_e.rd;
                end
            end else begin
                n_checks++;
                if (RD !== last_rd) begin
                    n_fail++;
                    $display("FAIL rd_hold: got RD=%08h, expected %08h", RD, last_rd);
                end
            end
        end
    end

    // Issue one request, scramble inputs while busy, check latency
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] wd);
        exp_t e;
        int   n;
        model_access(wr, a, f3, wd, e);
        exp_q.push_back(e);
        MemRead  = rd;
        MemWrite = wr;
        A        = a;
        funct3   = f3;
        WD       = wd;
        @(posedge clk); #1;
        n = 0;
        while (Ready !== 1'b1 && n < 40) begin
            MemRead  = 1'($urandom_range(0, 1));
            MemWrite = 1'($urandom_range(0, 1));
            A        = $urandom;
            funct3   = 3'($urandom_range(0, 7));
            WD       = $urandom;
            @(posedge clk); #1;
            n++;
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        n_checks++;
        if (n != LATENCY + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, expected %0d", n, LATENCY + 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Fill memory so every model byte is known
        for (int unsigned w = 0; w < DEPTH; w++) begin
            issue(1'b0, 1'b1, 32'(w * 4), 3'b010, $urandom);
        end

        // Word store/load
        issue(1'b0, 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 32'h10, 3'b010, 32'h0);

        // Byte stores, signed/unsigned byte loads, neighbouring bytes intact
        issue(1'b0, 1'b1, 32'h21, 3'b000, 32'h0000_007F);
        issue(1'b1, 1'b0, 32'h21, 3'b000, 32'h0);
        issue(1'b0, 1'b1, 32'h22, 3'b000, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 32'h22, 3'b000, 32'h0);
        issue(1'b1, 1'b0, 32'h22, 3'b100, 32'h0);
        issue(1'b1, 1'b0, 32'h20, 3'b010, 32'h0);

        // Halfword store, signed/unsigned halfword loads, word view
        issue(1'b0, 1'b1, 32'h32, 3'b001, 32'h0000_8001);
        issue(1'b1, 1'b0, 32'h32, 3'b001, 32'h0);
        issue(1'b1, 1'b0, 32'h32, 3'b101, 32'h0);
        issue(1'b1, 1'b0, 32'h30, 3'b010, 32'h0);

        // Reset while waiting aborts the store: no Ready, no write
        MemWrite = 1'b1;
        A        = 32'h40;
        funct3   = 3'b010;
        WD       = 32'h1234_5678;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 32'h40, 3'b010, 32'h0);

        // Misaligned word, address wrap, simultaneous read+write
        issue(1'b1, 1'b0, 32'h13, 3'b010, 32'h0);
        issue(1'b1, 1'b0, 32'h400, 3'b010, 32'h0);
        issue(1'b1, 1'b1, 32'h44, 3'b010, 32'hCAFE_F00D);
        issue(1'b1, 1'b0, 32'h44, 3'b010, 32'h0);
        issue(1'b1, 1'b0, 32'h33, 3'b001, 32'h0);
        issue(1'b1, 1'b0, 32'h2F, 3'b111, 32'h0);

        // Randomized mix over all funct3 encodings and addresses
        repeat (300) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            issue((op < 5) || (op == 9), (op >= 5), $urandom,
                  3'($urandom_range(0, 7)), $urandom);
        end

        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
